// File: rtl/multiplier_pkg.sv
// Shared operand width and Montgomery-encoder types for the multiply/reduce datapath.
package multiplier_pkg;

  localparam int DATA_LENGTH = 64;

  // Loop counter must hold 0..DATA_LENGTH inclusive.
  localparam int ENC_CNT_W = $clog2(DATA_LENGTH + 1);

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_LOAD,
    ENC_SHIFT,
    ENC_DONE
  } enc_state_e;

endpackage

// File: rtl/montgomery_encode_mod_double_step.sv
// One modular doubling step: res = (2*acc) mod q, assuming acc < q.
// The doubled value needs DATA_LENGTH+1 bits; after one conditional
// subtraction the result fits back into DATA_LENGTH bits.
module mod_double_step #(
  parameter int DATA_LENGTH = 64
) (
  input  logic [DATA_LENGTH-1:0] acc_i,
  input  logic [DATA_LENGTH-1:0] q_i,
  output logic [DATA_LENGTH-1:0] res_o
);

  logic [DATA_LENGTH:0]   dbl;
  logic [DATA_LENGTH-1:0] diff;

  // Double, then subtract q once if the doubled value reached it.
  // The low-width subtraction is exact: when dbl >= q the true difference is < q.
  always_comb begin
    dbl   = {acc_i, 1'b0};
    diff  = dbl[DATA_LENGTH-1:0] - q_i;
    res_o = (dbl >= {1'b0, q_i}) ? diff : dbl[DATA_LENGTH-1:0];
  end

endmodule

// File: rtl/montgomery_encode.sv
// Montgomery-form encoder: result = (x * 2^q_bl) mod q by iterative
// shift-and-conditional-subtract, one doubling per cycle.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ENC_IDLE  | waiting for start_i; operands captured on start
//   ENC_LOAD  | reduce x once into [0,q), load loop counter
//   ENC_SHIFT | one modular doubling per cycle until the counter hits 1
//   ENC_DONE  | valid_o high; a start_i here chains straight into LOAD
module montgomery_encode
  import multiplier_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] q_i,
  input  logic [DATA_LENGTH-1:0] q_bl_i,
  output logic                   busy_o,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o
);

  enc_state_e             state_q, state_d;
  logic [DATA_LENGTH-1:0] x_q, x_d;
  logic [DATA_LENGTH-1:0] q_q, q_d;
  logic [DATA_LENGTH-1:0] q_bl_q, q_bl_d;
  logic [DATA_LENGTH-1:0] acc_q, acc_d;
  logic [ENC_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] result_q, result_d;
  logic                   valid_q, valid_d;

  logic [DATA_LENGTH-1:0] load_val;
  logic [ENC_CNT_W-1:0]   cnt_load;
  logic [DATA_LENGTH-1:0] step_val;

  mod_double_step #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_step (
    .acc_i(acc_q),
    .q_i  (q_q),
    .res_o(step_val)
  );

  // Initial reduction of x (x < 2q, so one subtraction) and the clamped loop count;
  // clamping keeps the loop finite even for an out-of-range q_bl.
  always_comb begin
    load_val = (x_q >= q_q) ? (x_q - q_q) : x_q;
    cnt_load = (q_bl_q > DATA_LENGTH'(DATA_LENGTH)) ? ENC_CNT_W'(DATA_LENGTH)
                                                    : q_bl_q[ENC_CNT_W-1:0];
  end

  // Next-state and datapath updates for the encode sequence.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    q_d      = q_q;
    q_bl_d   = q_bl_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      ENC_IDLE, ENC_DONE: begin
        state_d = ENC_IDLE;
        if (start_i) begin
          x_d     = x_i;
          q_d     = q_i;
          q_bl_d  = q_bl_i;
          state_d = ENC_LOAD;
        end
      end
      ENC_LOAD: begin
        acc_d = load_val;
        cnt_d = cnt_load;
        if (cnt_load == '0) begin
          result_d = load_val;
          valid_d  = 1'b1;
          state_d  = ENC_DONE;
        end else begin
          state_d = ENC_SHIFT;
        end
      end
      ENC_SHIFT: begin
        acc_d = step_val;
        cnt_d = cnt_q - ENC_CNT_W'(1);
        if (cnt_q == ENC_CNT_W'(1)) begin
          result_d = step_val;
          valid_d  = 1'b1;
          state_d  = ENC_DONE;
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  // State, operand and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ENC_IDLE;
      x_q      <= '0;
      q_q      <= '0;
      q_bl_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      q_q      <= q_d;
      q_bl_q   <= q_bl_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o   = (state_q != ENC_IDLE);
  assign result_o = result_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_montgomery_encode.sv
// Directed and randomized checks for the Montgomery-form encoder.
module tb_montgomery_encode;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [63:0] x_i, q_i, q_bl_i;
  logic        busy_o;
  logic [63:0] result_o;
  logic        valid_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_valid = 0;

  montgomery_encode dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .x_i     (x_i),
    .q_i     (q_i),
    .q_bl_i  (q_bl_i),
    .busy_o  (busy_o),
    .result_o(result_o),
    .valid_o (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count every valid pulse, sampled mid-cycle.
  always @(negedge clk_i) if (valid_o) n_valid++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Launch one operation (start sampled at E0) and wait for valid_o.
  // lat is the edge index of the valid pulse relative to E0.
  task automatic run_op(input logic [63:0] x, input logic [63:0] q, input logic [63:0] qbl,
                        output logic [63:0] res, output int lat, output bit busy_ok);
    @(negedge clk_i);
    x_i = x; q_i = q; q_bl_i = qbl; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!valid_o && lat < 200) begin
      if (!busy_o) busy_ok = 1'b0;
      @(negedge clk_i);
      lat++;
    end
    if (!busy_o) busy_ok = 1'b0;
    res = result_o;
  endtask

  // Independent Montgomery reduction model: y * 2^-qbl mod q.
  function automatic logic [63:0] redc(input logic [63:0] y, input logic [63:0] q, input int qbl);
    logic [63:0]  inv, mask, m;
    logic [129:0] t;
    inv = q;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - q * inv);
    mask = (qbl >= 64) ? '1 : ((64'd1 << qbl) - 64'd1);
    m = ((y & mask) * (64'd0 - inv)) & mask;
    t = ({66'd0, y} + {66'd0, m} * {66'd0, q}) >> qbl;
    if (t >= {66'd0, q}) t = t - {66'd0, q};
    return t[63:0];
  endfunction

  logic [63:0] res, q, x, mask_b;
  int          lat, nv, b;
  bit          bok;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; x_i = '0; q_i = '0; q_bl_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst_ni = 1'b1;

    // 1: 3*32 mod 17 = 11, valid at E6, idle again after E7
    run_op(64'd3, 64'd17, 64'd5, res, lat, bok);
    chk("t1_result", res, 64'd11);
    chk("t1_latency", 64'(lat), 64'd6);
    chk("t1_busy", 64'(bok), 64'd1);
    @(negedge clk_i);
    chk("t1_valid_pulse", 64'(valid_o), 64'd0);
    chk("t1_idle", 64'(busy_o), 64'd0);
    chk("t1_hold", result_o, 64'd11);

    // 2: q_bl = 0, both x<q and x>=q
    run_op(64'd5, 64'd17, 64'd0, res, lat, bok);
    chk("t2_result_a", res, 64'd5);
    chk("t2_latency", 64'(lat), 64'd1);
    run_op(64'd20, 64'd17, 64'd0, res, lat, bok);
    chk("t2_result_b", res, 64'd3);

    // 3: full-width modulus, needs the overflow bit of the doubling
    run_op(64'hFFFFFFFFFFFFFFC4, 64'hFFFFFFFFFFFFFFC5, 64'd64, res, lat, bok);
    chk("t3_result", res, 64'hFFFFFFFFFFFFFF8A);
    chk("t3_latency", 64'(lat), 64'd65);
    chk("t3_busy", 64'(bok), 64'd1);

    // 4: start mid-operation ignored; start during DONE chains at E7
    @(negedge clk_i);
    @(negedge clk_i);
    x_i = 64'd3; q_i = 64'd17; q_bl_i = 64'd5; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    x_i = 64'd7; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("t4_no_early_valid", 64'(valid_o), 64'd0);
    @(negedge clk_i);
    chk("t4_valid_e6", 64'(valid_o), 64'd1);
    chk("t4_result_a", result_o, 64'd11);
    x_i = 64'd7; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("t4_chain_busy", 64'(busy_o), 64'd1);
    chk("t4_chain_hold", result_o, 64'd11);
    repeat (5) @(negedge clk_i);
    chk("t4_no_valid_e12", 64'(valid_o), 64'd0);
    @(negedge clk_i);
    chk("t4_valid_e13", 64'(valid_o), 64'd1);
    chk("t4_result_b", result_o, 64'd3);

    // 5: reset mid-operation
    @(negedge clk_i);
    @(negedge clk_i);
    x_i = 64'hFFFFFFFFFFFFFFC4; q_i = 64'hFFFFFFFFFFFFFFC5; q_bl_i = 64'd64; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("t5_busy_e20", 64'(busy_o), 64'd1);
    nv = n_valid;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy_o), 64'd0);
    chk("t5_rst_valid", 64'(valid_o), 64'd0);
    chk("t5_rst_result", result_o, 64'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (70) @(negedge clk_i);
    chk("t5_no_valid", 64'(n_valid - nv), 64'd0);
    chk("t5_idle", 64'(busy_o), 64'd0);
    run_op(64'd3, 64'd17, 64'd5, res, lat, bok);
    chk("t5_t1_result", res, 64'd11);
    chk("t5_t1_latency", 64'(lat), 64'd6);

    // 6: random round trip through a Montgomery reduction model
    for (int i = 0; i < 1000; i++) begin
      b = $urandom_range(1, 64);
      mask_b = (b == 64) ? '1 : ((64'd1 << b) - 64'd1);
      q = ({$urandom, $urandom} & mask_b) | (64'd1 << (b - 1)) | 64'd1;
      x = {$urandom, $urandom} % q;
      run_op(x, q, 64'(b), res, lat, bok);
      chk("t6_redc", redc(res, q, b), x);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
